// File: rtl/mem_arbiter.sv
// Two-master memory arbiter: one access per two cycles, alternating priority with an
// optional locked burst, and a read-return pulse routed back to the issuing master.
module mem_arbiter #(
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_req,
    input  logic [1:0]        m0_cmd,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_lock,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic [1:0]        m1_cmd,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_lock,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,

    output logic [1:0]        mem_cmd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int              BW        = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0]   BURST_MAX = BW'(MAX_BURST);
    localparam logic [1:0]      CMD_NONE  = 2'b00;
    localparam logic [1:0]      CMD_RD    = 2'b01;
    localparam logic [1:0]      CMD_WR    = 2'b10;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t            state;
    state_t            state_nxt;

    logic              elig0;
    logic              elig1;
    logic              grant;
    logic              win_nxt;
    logic              win_lock;
    logic              last_win;
    logic [BW-1:0]     burst_cnt;
    logic [BW-1:0]     burst_nxt;

    logic              win_p1;
    logic [1:0]        cmd_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic [DATA_W-1:0] wdata_p1;
    logic              gnt0_p1;
    logic              gnt1_p1;
    logic              rvld0_p2;
    logic              rvld1_p2;

    function automatic logic is_access(input logic [1:0] cmd);
        return (cmd == CMD_RD) || (cmd == CMD_WR);
    endfunction

    assign elig0 = m0_req && is_access(m0_cmd);
    assign elig1 = m1_req && is_access(m1_cmd);

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        win_nxt   = last_win;
        win_lock  = 1'b0;
        burst_nxt = burst_cnt;
        case (state)
            IDLE: begin
                if (elig0 || elig1) begin
                    grant     = 1'b1;
                    state_nxt = ISSUE;
                    if (elig0 && elig1) begin
                        // the previous winner keeps the port only while its locked burst lasts
                        if ((last_win ? m1_lock : m0_lock) && (burst_cnt < BURST_MAX))
                            win_nxt = last_win;
                        else
                            win_nxt = ~last_win;
                    end else begin
                        win_nxt = elig1;
                    end
                    win_lock = win_nxt ? m1_lock : m0_lock;
                    if (!win_lock)
                        burst_nxt = '0;
                    else if (win_nxt != last_win)
                        burst_nxt = BW'(1);
                    else if (burst_cnt < BURST_MAX)
                        burst_nxt = burst_cnt + BW'(1);
                end
            end
            ISSUE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            last_win  <= 1'b1;
            burst_cnt <= '0;
            win_p1    <= 1'b0;
            cmd_p1    <= CMD_NONE;
            addr_p1   <= '0;
            wdata_p1  <= '0;
            gnt0_p1   <= 1'b0;
            gnt1_p1   <= 1'b0;
            rvld0_p2  <= 1'b0;
            rvld1_p2  <= 1'b0;
        end else begin
            state <= state_nxt;
            // p1 -> p2: read data returns the cycle after the issue
            rvld0_p2 <= (state == ISSUE) && (cmd_p1 == CMD_RD) && !win_p1;
            rvld1_p2 <= (state == ISSUE) && (cmd_p1 == CMD_RD) &&  win_p1;
            // arbitration -> p1: the winner's access is presented for one cycle
            if (grant) begin
                last_win  <= win_nxt;
                burst_cnt <= burst_nxt;
                win_p1    <= win_nxt;
                cmd_p1    <= win_nxt ? m1_cmd   : m0_cmd;
                addr_p1   <= win_nxt ? m1_addr  : m0_addr;
                wdata_p1  <= win_nxt ? m1_wdata : m0_wdata;
                gnt0_p1   <= !win_nxt;
                gnt1_p1   <=  win_nxt;
            end else begin
                cmd_p1    <= CMD_NONE;
                gnt0_p1   <= 1'b0;
                gnt1_p1   <= 1'b0;
            end
        end
    end

    assign mem_cmd   = cmd_p1;
    assign mem_addr  = addr_p1;
    assign mem_wdata = wdata_p1;
    assign m0_gnt    = gnt0_p1;
    assign m1_gnt    = gnt1_p1;
    assign m0_rvalid = rvld0_p2;
    assign m1_rvalid = rvld1_p2;
    assign m0_rdata  = mem_rdata;
    assign m1_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model built on a grant history queue.
module tb_mem_arbiter;

    localparam int AW   = 9;
    localparam int DW   = 16;
    localparam int MAXB = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          m0_req, m0_lock, m0_gnt, m0_rvalid;
    logic [1:0]    m0_cmd;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic          m1_req, m1_lock, m1_gnt, m1_rvalid;
    logic [1:0]    m1_cmd;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic [1:0]    mem_cmd;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int n_chk = 0;
    int n_err = 0;

    // reference model state
    bit            e_issue;
    int            e_win;
    logic [1:0]    e_cmd;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [1:0]    e_rv;
    int            last_w;
    int            hist_w[$];
    bit            hist_l[$];

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MAXB)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_cmd(m0_cmd), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_lock(m0_lock), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_cmd(m1_cmd), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        e_issue = 1'b0;
        e_win   = 0;
        e_cmd   = 2'b00;
        e_addr  = '0;
        e_wdata = '0;
        e_rv    = 2'b00;
        last_w  = 1;
        hist_w.delete();
        hist_l.delete();
    endfunction

    // consecutive locked grants to the last winner, counted back through history
    function automatic int streak();
        int n = 0;
        for (int i = hist_w.size() - 1; i >= 0; i--) begin
            if (hist_w[i] != last_w || !hist_l[i]) break;
            n++;
        end
        return n;
    endfunction

    function automatic void model_step();
        bit e0, e1, lk;
        int w;
        e0   = (m0_req === 1'b1) && (m0_cmd == 2'b01 || m0_cmd == 2'b10);
        e1   = (m1_req === 1'b1) && (m1_cmd == 2'b01 || m1_cmd == 2'b10);
        e_rv = 2'b00;
        if (e_issue) begin
            if (e_cmd == 2'b01) e_rv = (e_win == 1) ? 2'b10 : 2'b01;
            e_issue = 1'b0;
            e_cmd   = 2'b00;
        end else if (e0 || e1) begin
            if (e0 && e1) begin
                lk = (last_w == 1) ? m1_lock : m0_lock;
                w  = (lk && streak() < MAXB) ? last_w : 1 - last_w;
            end else begin
                w = e1 ? 1 : 0;
            end
            e_issue = 1'b1;
            e_win   = w;
            e_cmd   = w ? m1_cmd   : m0_cmd;
            e_addr  = w ? m1_addr  : m0_addr;
            e_wdata = w ? m1_wdata : m0_wdata;
            hist_w.push_back(w);
            hist_l.push_back(w ? m1_lock : m0_lock);
            if (hist_w.size() > 8) begin
                void'(hist_w.pop_front());
                void'(hist_l.pop_front());
            end
            last_w = w;
        end
    endfunction

    task automatic check_outputs();
        chk("mem_cmd",   mem_cmd,   e_cmd);
        chk("mem_addr",  mem_addr,  e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
        chk("gnt",       {m1_gnt, m0_gnt}, e_issue ? ((e_win == 1) ? 2'b10 : 2'b01) : 2'b00);
        chk("rvalid",    {m1_rvalid, m0_rvalid}, e_rv);
        chk("rdata",     {m1_rdata, m0_rdata}, {mem_rdata, mem_rdata});
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        model_step();
        check_outputs();
    endtask

    task automatic assert_reset();
        reset = 1'b0;
        #1;
        model_reset();
        check_outputs();
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        check_outputs();
    endtask

    task automatic idle_masters();
        m0_req = 1'b0; m0_cmd = 2'b00; m0_addr = '0; m0_wdata = '0; m0_lock = 1'b0;
        m1_req = 1'b0; m1_cmd = 2'b00; m1_addr = '0; m1_wdata = '0; m1_lock = 1'b0;
    endtask

    task automatic new_txn(output logic req, output logic [1:0] cmd, output logic [AW-1:0] addr,
                           output logic [DW-1:0] wdata, output logic lock);
        int r;
        r     = $urandom_range(0, 7);
        req   = ($urandom_range(0, 3) != 0);
        cmd   = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (r[0] ? 2'b01 : 2'b10);
        addr  = AW'($urandom);
        wdata = DW'($urandom);
        lock  = ($urandom_range(0, 2) != 0);
    endtask

    initial begin
        logic [15:0] seq;
        int          g;
        idle_masters();
        mem_rdata = '0;

        // single m0 read with data return
        assert_reset();
        release_reset();
        m0_req = 1'b1; m0_cmd = 2'b01; m0_addr = 9'h005; mem_rdata = 16'hBEEF;
        cycle();
        chk("rd_issue_cmd",  mem_cmd, 2'b01);
        chk("rd_issue_addr", mem_addr, 9'h005);
        chk("rd_issue_gnt",  {m1_gnt, m0_gnt}, 2'b01);
        m0_req = 1'b0;
        cycle();
        chk("rd_ret_rvalid", {m1_rvalid, m0_rvalid}, 2'b01);
        chk("rd_ret_rdata",  m0_rdata, 16'hBEEF);
        chk("rd_ret_gnt",    {m1_gnt, m0_gnt}, 2'b00);

        // m1 write at the top address, no rvalid after
        m1_req = 1'b1; m1_cmd = 2'b10; m1_addr = 9'h1FF; m1_wdata = 16'h1234;
        cycle();
        chk("wr_cmd",   mem_cmd, 2'b10);
        chk("wr_addr",  mem_addr, 9'h1FF);
        chk("wr_wdata", mem_wdata, 16'h1234);
        chk("wr_gnt",   {m1_gnt, m0_gnt}, 2'b10);
        m1_req = 1'b0;
        g = 0;
        repeat (3) begin
            cycle();
            g += int'(m0_rvalid) + int'(m1_rvalid);
        end
        chk("wr_no_rvalid", g, 0);

        // illegal command never granted
        m0_req = 1'b1; m0_cmd = 2'b11;
        g = 0;
        repeat (10) begin
            cycle();
            if (m0_gnt || m1_gnt || mem_cmd != 2'b00) g++;
        end
        chk("cmd11_ignored", g, 0);
        m0_req = 1'b0;

        // reset in the middle of a read issue
        m0_req = 1'b1; m0_cmd = 2'b01; m0_addr = 9'h0AA;
        cycle();
        chk("rst_pre_gnt", m0_gnt, 1'b1);
        reset = 1'b0;
        #1;
        model_reset();
        chk("rst_now_cmd",  mem_cmd, 2'b00);
        chk("rst_now_gnt",  m0_gnt, 1'b0);
        chk("rst_now_addr", mem_addr, 9'h000);
        m0_req = 1'b0;
        release_reset();
        g = 0;
        repeat (4) begin
            cycle();
            g += int'(m0_rvalid);
        end
        chk("rst_no_rvalid", g, 0);

        // round robin between two unlocked readers
        assert_reset();
        release_reset();
        m0_req = 1'b1; m0_cmd = 2'b01; m0_addr = 9'h010; m0_lock = 1'b0;
        m1_req = 1'b1; m1_cmd = 2'b01; m1_addr = 9'h020; m1_lock = 1'b0;
        seq = '0;
        repeat (8) begin
            cycle();
            seq = {seq[13:0], m1_gnt, m0_gnt};
        end
        chk("rr_order", seq, 16'h4848);

        // locked burst from m1 against a continuous m0 reader
        assert_reset();
        release_reset();
        m1_lock = 1'b1;
        seq = '0;
        g = 0;
        repeat (20) begin
            cycle();
            if (m0_gnt || m1_gnt) begin
                seq = {seq[14:0], m1_gnt};
                g++;
            end
        end
        chk("lock_count", g, 10);
        chk("lock_order", seq, 16'h03DE);

        // locked master alone keeps winning past the burst limit
        m0_req = 1'b0;
        g = 0;
        repeat (12) begin
            cycle();
            g += int'(m1_gnt);
        end
        chk("lock_alone", g, 6);

        // randomized traffic
        idle_masters();
        for (int i = 0; i < 1500; i++) begin
            if (i == 750) begin
                assert_reset();
                release_reset();
            end
            if (m0_gnt || !m0_req)
                new_txn(m0_req, m0_cmd, m0_addr, m0_wdata, m0_lock);
            else if ($urandom_range(0, 15) == 0)
                m0_req = 1'b0;
            if (m1_gnt || !m1_req)
                new_txn(m1_req, m1_cmd, m1_addr, m1_wdata, m1_lock);
            else if ($urandom_range(0, 15) == 0)
                m1_req = 1'b0;
            mem_rdata = DW'($urandom);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
